uart_rx: RTL and testbench

Standalone UART receiver, the receive-side counterpart of the UART transmitter. It oversamples `serial_in` with `CLOCKS_PER_BIT` clocks per bit, synchronizes it through three flip-flops, and deframes start, data, optional parity and stop bits. It presents each received word with a one-cycle valid pulse and flags parity and framing errors. It sits between the pad or loopback wire and the host logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - rx_state_t                 : 3-bit receiver state encoding
//   - NUMBER_OF_RX_SYNCHRONIZERS : depth of the serial input synchronizer
//   - parity_bit()               : parity bit for a data word and parity type
package uart_pkg;

    localparam int NUMBER_OF_RX_SYNCHRONIZERS = 3;

    typedef enum logic [2:0] {
        RX_IDLE       = 3'd0,
        RX_START_BIT  = 3'd1,
        RX_DATA_BITS  = 3'd2,
        RX_PARITY_BIT = 3'd3,
        RX_STOP_BIT   = 3'd4
    } rx_state_t;

    // parity_type: 0 = even, 1 = odd. Unused upper bits of data must be zero.
    function automatic logic parity_bit(input logic [31:0] data, input logic parity_type);
        return (^data) ^ parity_type;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-stage flip-flop synchronizer for an asynchronous level.
// All stages reset to 1, which is the idle level of a UART line.
//   clk   : sampling clock
//   reset : asynchronous, active-low reset
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module uart_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Deframes start, data (LSB first),
// optional parity and stop bits from a synchronized copy of serial_in.
//   clk           : system clock
//   reset         : asynchronous, active-low reset
//   serial_in     : asynchronous serial line, idles high
//   received_data : last good word, held until the next good frame
//   data_is_valid : one-cycle pulse when a good frame completes
//   rx_error      : one-cycle pulse on a parity or framing error
//   rx_busy       : high whenever the receiver is not idle
//
// state         | meaning
// --------------+---------------------------------------------------------
// RX_IDLE       | waiting for sync to go low (start edge)
// RX_START_BIT  | counting to mid start bit; rejects glitches (false start)
// RX_DATA_BITS  | sampling data bits mid-bit, LSB first, running parity
// RX_PARITY_BIT | sampling parity bit and latching a mismatch flag
// RX_STOP_BIT   | sampling stop bit; reports the frame and returns to idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        rx_busy
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W = $clog2(INPUT_DATA_WIDTH);

    localparam logic [CNT_W-1:0] MID_START   = CNT_W'(CLOCKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(INPUT_DATA_WIDTH - 1);
    localparam logic             ODD_PARITY  = (PARITY_TYPE != 0);

    logic                        sync;
    rx_state_t                   state;
    logic [CNT_W-1:0]            sample_cnt;
    logic [IDX_W-1:0]            bit_idx;
    logic [INPUT_DATA_WIDTH-1:0] shift_reg;
    logic                        running_parity;
    logic                        parity_mismatch;
    logic                        sample_tick;

    uart_sync #(
        .STAGES (NUMBER_OF_RX_SYNCHRONIZERS)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_in),
        .q     (sync)
    );

    // After the start-bit check the counter restarts at 0, so every wrap at
    // CLOCKS_PER_BIT-1 lands one full bit later, i.e. again at mid-bit.
    assign sample_tick = (sample_cnt == LAST_SAMPLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= RX_IDLE;
            sample_cnt      <= '0;
            bit_idx         <= '0;
            shift_reg       <= '0;
            running_parity  <= 1'b0;
            parity_mismatch <= 1'b0;
            received_data   <= '0;
            data_is_valid   <= 1'b0;
            rx_error        <= 1'b0;
            rx_busy         <= 1'b0;
        end else begin
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;

            case (state)
                RX_IDLE: begin
                    if (!sync) begin
                        state      <= RX_START_BIT;
                        sample_cnt <= '0;
                        rx_busy    <= 1'b1;
                    end
                end

                RX_START_BIT: begin
                    if (sample_cnt == MID_START) begin
                        if (sync) begin
                            state   <= RX_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state           <= RX_DATA_BITS;
                            bit_idx         <= '0;
                            sample_cnt      <= '0;
                            running_parity  <= 1'b0;
                            parity_mismatch <= 1'b0;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end

                RX_DATA_BITS: begin
                    if (sample_tick) begin
                        sample_cnt     <= '0;
                        shift_reg      <= {sync, shift_reg[INPUT_DATA_WIDTH-1:1]};
                        running_parity <= running_parity ^ sync;
                        if (bit_idx == LAST_BIT) begin
                            state <= (PARITY_ENABLED != 0) ? RX_PARITY_BIT : RX_STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end

                RX_PARITY_BIT: begin
                    if (sample_tick) begin
                        sample_cnt      <= '0;
                        parity_mismatch <= (sync != parity_bit(32'(running_parity), ODD_PARITY));
                        state           <= RX_STOP_BIT;
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end

                RX_STOP_BIT: begin
                    if (sample_tick) begin
                        // Leaving at mid-stop lets a start edge in the second
                        // half of the stop bit begin the next frame.
                        sample_cnt <= '0;
                        state      <= RX_IDLE;
                        rx_busy    <= 1'b0;
                        if (sync && !parity_mismatch) begin
                            received_data <= shift_reg;
                            data_is_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= RX_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Two receivers (even and odd
// parity) listen to the same line; the frame driver predicts each one's
// outcome from the frame contents and queues it, and per-receiver monitors
// compare every pulse (timing, kind, data, busy) against the queue.
module tb_uart_rx;

    localparam int W        = 8;
    localparam int CPB      = 8;
    // pulse appears 3 + CPB/2 + (1+W+1)*CPB edges after the first low sample
    localparam int LATENCY  = 3 + CPB/2 + (1 + W + 1) * CPB;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic [7:0] rd_even, rd_odd;
    logic       v_even, v_odd, err_even, err_odd, busy_even, busy_odd;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q_even[$];
    exp_t q_odd[$];
    exp_t e_even, e_odd;
    logic [7:0] good_even = 8'h00;
    logic [7:0] good_odd  = 8'h00;

    uart_rx #(
        .INPUT_DATA_WIDTH (W),
        .PARITY_ENABLED   (1),
        .PARITY_TYPE      (0),
        .CLOCKS_PER_BIT   (CPB)
    ) dut_even (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .received_data (rd_even),
        .data_is_valid (v_even),
        .rx_error      (err_even),
        .rx_busy       (busy_even)
    );

    uart_rx #(
        .INPUT_DATA_WIDTH (W),
        .PARITY_ENABLED   (1),
        .PARITY_TYPE      (1),
        .CLOCKS_PER_BIT   (CPB)
    ) dut_odd (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .received_data (rd_odd),
        .data_is_valid (v_odd),
        .rx_error      (err_odd),
        .rx_busy       (busy_odd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic compare_pulse(input string tag, input exp_t e, input logic v,
                                 input logic er, input logic [7:0] rd, input logic b);
        check({tag, "_time"}, 32'(cyc), 32'(e.at));
        check({tag, "_both_pulses"}, 32'(v & er), 32'd0);
        check({tag, "_kind_is_error"}, 32'(er), 32'(e.is_err));
        check({tag, "_data"}, 32'(rd), 32'(e.data));
        check({tag, "_busy"}, 32'(b), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (v_even || err_even) begin
                if (q_even.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL even_unexpected_pulse: valid=%0b error=%0b, no frame pending (cycle %0d)",
                             v_even, err_even, cyc);
                end else begin
                    e_even = q_even.pop_front();
                    compare_pulse("even", e_even, v_even, err_even, rd_even, busy_even);
                end
            end else if (q_even.size() != 0 && cyc > q_even[0].at) begin
                vectors++;
                miscompares++;
                $display("FAIL even_missing_pulse: pulse absent, expected at cycle %0d", q_even[0].at);
                void'(q_even.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (v_odd || err_odd) begin
                if (q_odd.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL odd_unexpected_pulse: valid=%0b error=%0b, no frame pending (cycle %0d)",
                             v_odd, err_odd, cyc);
                end else begin
                    e_odd = q_odd.pop_front();
                    compare_pulse("odd", e_odd, v_odd, err_odd, rd_odd, busy_odd);
                end
            end else if (q_odd.size() != 0 && cyc > q_odd[0].at) begin
                vectors++;
                miscompares++;
                $display("FAIL odd_missing_pulse: pulse absent, expected at cycle %0d", q_odd[0].at);
                void'(q_odd.pop_front());
            end
        end
    end

    // Reference: a frame is good for a receiver when the sent parity bit
    // equals (count of ones in data) mod 2, inverted for odd parity, and the
    // stop bit is 1. Good frames update that receiver's held word.
    task automatic predict(input logic [7:0] d, input logic sent_par, input logic stop, input int at);
        int   ones;
        logic want_even, want_odd;
        exp_t e;
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        want_even = logic'(ones % 2);
        want_odd  = ~want_even;
        e.at = at;
        e.is_err = (sent_par != want_even) || !stop;
        if (!e.is_err) good_even = d;
        e.data = good_even;
        q_even.push_back(e);
        e.is_err = (sent_par != want_odd) || !stop;
        if (!e.is_err) good_odd = d;
        e.data = good_odd;
        q_odd.push_back(e);
    endtask

    // Called right after a falling clk edge. flip inverts the even-parity bit.
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
        logic sent_par;
        sent_par = (^d) ^ flip;
        predict(d, sent_par, stop, cyc + 1 + LATENCY);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < W; i++) begin
            serial_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = sent_par;
        repeat (CPB) @(negedge clk);
        serial_in = stop;
        repeat (CPB) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q_even.size() != 0 || q_odd.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (q_even.size() != 0 || q_odd.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d even and %0d odd results still pending",
                     q_even.size(), q_odd.size());
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_even_data"},  32'(rd_even),   32'd0);
        check({tag, "_even_valid"}, 32'(v_even),    32'd0);
        check({tag, "_even_error"}, 32'(err_even),  32'd0);
        check({tag, "_even_busy"},  32'(busy_even), 32'd0);
        check({tag, "_odd_data"},   32'(rd_odd),    32'd0);
        check({tag, "_odd_valid"},  32'(v_odd),     32'd0);
        check({tag, "_odd_error"},  32'(err_odd),   32'd0);
        check({tag, "_odd_busy"},   32'(busy_odd),  32'd0);
    endtask

    initial begin
        int   c;
        logic [7:0] d;
        logic flip, stop;

        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        idle(10);

        // good frame, even parity
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(5);
        // parity bit forced to 1 (even receiver errors, odd accepts)
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(5);
        // framing error
        send_frame(8'h0F, 1'b0, 1'b0);
        idle(20);
        drain();

        // false start: 2-cycle glitch
        c = cyc;
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_high", 32'(busy_even), 32'd1);
        repeat (4) @(negedge clk);
        check("glitch_busy_low_even", 32'(busy_even), 32'd0);
        check("glitch_busy_low_odd", 32'(busy_odd), 32'd0);
        check("glitch_cycles", 32'(cyc - c), 32'd9);
        idle(5);
        send_frame(8'h55, 1'b0, 1'b1);
        idle(3);

        // back-to-back frames, no idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        // 8'h01 with parity bit 0: good for odd parity only
        send_frame(8'h01, 1'b1, 1'b1);
        idle(5);
        drain();

        // reset during data bit 4
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        d = 8'h9A;
        for (int i = 0; i < 4; i++) begin
            serial_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = d[4];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        good_even = 8'h00;
        good_odd  = 8'h00;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        reset = 1'b1;
        idle(20);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(5);
        drain();

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 6) != 0);
            send_frame(d, flip, stop);
            if (stop) idle($urandom_range(0, 12));
            else      idle(16 + $urandom_range(0, 8));
        end
        idle(5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
